// File: rtl/sdhci_seq_pkg.sv
// Shared types and constants for the SDHCI command sequencer: OBI structs,
// SDHCI register offsets, command-flag layout and the sequencer state enum.
package sdhci_seq_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  localparam logic [31:0] RegArgument    = 32'h0000_0008;
  localparam logic [31:0] RegCommand     = 32'h0000_000C;
  localparam logic [31:0] RegResponse0   = 32'h0000_0010;
  localparam logic [31:0] RegIntStatus   = 32'h0000_0030;
  localparam logic [31:0] RegIntStatusEn = 32'h0000_0034;

  // cmd_flags_i = {type[1:0], data_present, idx_chk, crc_chk, 1'b0, resp_type[1:0]}
  localparam int unsigned FlagRespTypeLsb = 0;
  localparam int unsigned FlagCrcChk      = 3;
  localparam int unsigned FlagIdxChk      = 4;
  localparam int unsigned FlagDataPresent = 5;
  localparam int unsigned FlagTypeLsb     = 6;

  localparam int unsigned IntCmdComplete = 0;
  localparam int unsigned IntErrorInt    = 15;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StWrArg,
    StWrCmd,
    StRdStat,
    StWrClr,
    StRdResp,
    StDone
  } seq_state_e;

endpackage

// File: rtl/sdhci_obi_single_master.sv
// Single-outstanding OBI manager: a start pulse launches one transaction,
// done_o flags its response beat together with rdata_o/err_o.
module sdhci_obi_single_master
  import sdhci_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        idle_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output obi_req_t    obi_req_o,
  input  obi_rsp_t    obi_rsp_i
);

  logic        req_q, req_d;
  logic        wait_q, wait_d;
  obi_a_chan_t a_q, a_d;

  always_comb begin
    req_d  = req_q;
    wait_d = wait_q;
    a_d    = a_q;
    if (req_q && obi_rsp_i.gnt) begin
      req_d  = 1'b0;
      wait_d = 1'b1;
    end
    if (wait_q && obi_rsp_i.rvalid) begin
      wait_d = 1'b0;
    end
    // The caller only starts when idle or on the done beat, so req rises the cycle after.
    if (start_i) begin
      req_d      = 1'b1;
      a_d.addr   = addr_i;
      a_d.we     = we_i;
      a_d.be     = be_i;
      a_d.wdata  = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q  <= 1'b0;
      wait_q <= 1'b0;
      a_q    <= '0;
    end else begin
      req_q  <= req_d;
      wait_q <= wait_d;
      a_q    <= a_d;
    end
  end

  assign idle_o        = !req_q && !wait_q;
  assign done_o        = wait_q && obi_rsp_i.rvalid;
  assign rdata_o       = obi_rsp_i.r.rdata;
  assign err_o         = obi_rsp_i.r.err;
  assign obi_req_o.req = req_q;
  assign obi_req_o.a   = a_q;

endmodule

// File: rtl/sdhci_cmd_sequencer.sv
// Runs one SD command per request on the SDHCI register file over OBI:
// argument/command writes, status polling, status clear, response read.
module sdhci_cmd_sequencer
  import sdhci_seq_pkg::*;
#(
  parameter int unsigned PollLimit = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  input  logic [7:0]  cmd_flags_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [15:0] rsp_err_status_o,
  output logic        rsp_timeout_o,
  output logic        rsp_bus_err_o,
  output obi_req_t    obi_req_o,
  input  obi_rsp_t    obi_rsp_i
);

  localparam int unsigned PollCntW =
      ($clog2(PollLimit + 1) > 10) ? $clog2(PollLimit + 1) : 10;
  localparam logic [PollCntW-1:0] PollMax = PollCntW'(PollLimit);

  seq_state_e          state_q, state_d;
  logic [5:0]          index_q, index_d;
  logic [31:0]         arg_q, arg_d;
  logic [7:0]          flags_q, flags_d;
  logic [PollCntW-1:0] poll_cnt_q, poll_cnt_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic [15:0]         err_status_q, err_status_d;
  logic                timeout_q, timeout_d;
  logic                bus_err_q, bus_err_d;

  logic        start;
  logic [31:0] t_addr, t_wdata;
  logic        t_we;
  logic [3:0]  t_be;
  logic        eng_idle, eng_done, eng_err;
  logic [31:0] eng_rdata;

  sdhci_obi_single_master u_obi (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start),
    .addr_i    (t_addr),
    .we_i      (t_we),
    .be_i      (t_be),
    .wdata_i   (t_wdata),
    .idle_o    (eng_idle),
    .done_o    (eng_done),
    .rdata_o   (eng_rdata),
    .err_o     (eng_err),
    .obi_req_o (obi_req_o),
    .obi_rsp_i (obi_rsp_i)
  );

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    arg_d        = arg_q;
    flags_d      = flags_q;
    poll_cnt_d   = poll_cnt_q;
    rsp_data_d   = rsp_data_q;
    err_status_d = err_status_q;
    timeout_d    = timeout_q;
    bus_err_d    = bus_err_q;
    start        = 1'b0;

    unique case (state_q)
      StInit: begin
        if (eng_idle) begin
          start = 1'b1;
        end else if (eng_done) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (cmd_valid_i) begin
          index_d      = cmd_index_i;
          arg_d        = cmd_arg_i;
          flags_d      = cmd_flags_i;
          poll_cnt_d   = '0;
          rsp_data_d   = '0;
          err_status_d = '0;
          timeout_d    = 1'b0;
          bus_err_d    = 1'b0;
          state_d      = StWrArg;
          start        = 1'b1;
        end
      end
      StDone: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: begin
        if (eng_done && eng_err) begin
          bus_err_d = 1'b1;
          state_d   = StDone;
        end else if (eng_done) begin
          case (state_q)
            StWrArg: begin
              state_d = StWrCmd;
              start   = 1'b1;
            end
            StWrCmd: begin
              state_d = StRdStat;
              start   = 1'b1;
            end
            StRdStat: begin
              poll_cnt_d = (poll_cnt_q == PollMax) ? poll_cnt_q : poll_cnt_q + PollCntW'(1);
              if (eng_rdata[IntErrorInt] || eng_rdata[IntCmdComplete]) begin
                err_status_d = eng_rdata[31:16];
                state_d      = StWrClr;
                start        = 1'b1;
              end else if (poll_cnt_d == PollMax) begin
                timeout_d = 1'b1;
                state_d   = StDone;
              end else begin
                start = 1'b1;
              end
            end
            StWrClr: begin
              if (flags_q[FlagRespTypeLsb +: 2] != 2'b00) begin
                state_d = StRdResp;
                start   = 1'b1;
              end else begin
                state_d = StDone;
              end
            end
            StRdResp: begin
              rsp_data_d = eng_rdata;
              state_d    = StDone;
            end
            default: ;
          endcase
        end
      end
    endcase

    // A-channel for the transaction launched towards state_d.
    t_addr  = '0;
    t_we    = 1'b0;
    t_be    = 4'b1111;
    t_wdata = '0;
    unique case (state_d)
      StInit: begin
        t_addr  = RegIntStatusEn;
        t_we    = 1'b1;
        t_wdata = {16'hFFFF, 16'h0001};
      end
      StWrArg: begin
        t_addr  = RegArgument;
        t_we    = 1'b1;
        t_wdata = arg_d;
      end
      StWrCmd: begin
        t_addr  = RegCommand;
        t_we    = 1'b1;
        t_be    = 4'b1100;
        t_wdata = {2'b00, index_q, flags_q, 16'h0000};
      end
      StRdStat: t_addr = RegIntStatus;
      StWrClr: begin
        t_addr  = RegIntStatus;
        t_we    = 1'b1;
        t_wdata = {err_status_d, eng_rdata[IntErrorInt], 14'b0, 1'b1};
      end
      StRdResp: t_addr = RegResponse0;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StInit;
      index_q      <= '0;
      arg_q        <= '0;
      flags_q      <= '0;
      poll_cnt_q   <= '0;
      rsp_data_q   <= '0;
      err_status_q <= '0;
      timeout_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      arg_q        <= arg_d;
      flags_q      <= flags_d;
      poll_cnt_q   <= poll_cnt_d;
      rsp_data_q   <= rsp_data_d;
      err_status_q <= err_status_d;
      timeout_q    <= timeout_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign cmd_ready_o      = (state_q == StIdle);
  assign rsp_valid_o      = (state_q == StDone);
  assign rsp_data_o       = rsp_data_q;
  assign rsp_err_status_o = err_status_q;
  assign rsp_timeout_o    = timeout_q;
  assign rsp_bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_sdhci_cmd_sequencer.sv
// Bench for sdhci_cmd_sequencer: OBI subordinate model plus a transaction-list
// reference model, directed scenarios followed by randomized commands.
module tb_sdhci_cmd_sequencer;
  import sdhci_seq_pkg::*;

  localparam int unsigned TbPollLimit = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg, rsp_data;
  logic [7:0]  cmd_flags;
  logic [15:0] rsp_err_status;
  logic        rsp_timeout, rsp_bus_err;
  obi_req_t    obi_req;
  obi_rsp_t    obi_rsp;

  always #5 clk = ~clk;

  sdhci_cmd_sequencer #(.PollLimit(TbPollLimit)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .cmd_index_i      (cmd_index),
    .cmd_arg_i        (cmd_arg),
    .cmd_flags_i      (cmd_flags),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_data_o       (rsp_data),
    .rsp_err_status_o (rsp_err_status),
    .rsp_timeout_o    (rsp_timeout),
    .rsp_bus_err_o    (rsp_bus_err),
    .obi_req_o        (obi_req),
    .obi_rsp_i        (obi_rsp)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Subordinate scenario knobs
  logic [31:0] stat_q[$];
  logic [31:0] resp_val;
  int          err_at    = -1;
  int          gnt_fixed = 0;
  int          txn_cnt   = 0;
  obi_a_chan_t obs_q[$];

  // Reference model results
  obi_a_chan_t exp_q[$];
  logic [31:0] exp_data;
  logic [15:0] exp_err;
  logic        exp_to, exp_berr;

  initial begin : subordinate
    logic        stall, pend, pend_err;
    logic [31:0] pend_rdata;
    obi_a_chan_t prev_a;
    int          wait_cnt, cur_delay;
    stall = 1'b0; pend = 1'b0; pend_err = 1'b0; pend_rdata = '0;
    prev_a = '0; wait_cnt = 0; cur_delay = 0;
    obi_rsp = '0;
    forever begin
      @(negedge clk);
      obi_rsp = '0;
      if (rst) begin
        pend  = 1'b0;
        stall = 1'b0;
      end else if (pend) begin
        check_eq("no req in rvalid cycle", 32'(obi_req.req), 32'd0);
        obi_rsp.rvalid  = 1'b1;
        obi_rsp.r.rdata = pend_rdata;
        obi_rsp.r.err   = pend_err;
        pend = 1'b0;
      end else if (obi_req.req) begin
        if (stall) begin
          check_eq("a-channel stable while ungranted", 32'(obi_req.a == prev_a), 32'd1);
        end else begin
          cur_delay = (gnt_fixed >= 0) ? gnt_fixed : int'($urandom_range(0, 2));
          wait_cnt  = 0;
        end
        if (wait_cnt == cur_delay) begin
          obi_rsp.gnt = 1'b1;
          stall       = 1'b0;
          pend        = 1'b1;
          pend_err    = (txn_cnt == err_at);
          txn_cnt++;
          obs_q.push_back(obi_req.a);
          pend_rdata = '0;
          if (!obi_req.a.we && obi_req.a.addr == 32'h30)
            pend_rdata = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h0;
          else if (!obi_req.a.we && obi_req.a.addr == 32'h10)
            pend_rdata = resp_val;
        end else begin
          wait_cnt++;
          stall  = 1'b1;
          prev_a = obi_req.a;
        end
      end
    end
  end

  function automatic obi_a_chan_t mk(input logic [31:0] addr, input logic we,
                                     input logic [3:0] be, input logic [31:0] wdata);
    obi_a_chan_t t;
    t.addr = addr; t.we = we; t.be = be; t.wdata = wdata;
    return t;
  endfunction

  // Appends a transaction; returns 1 when the subordinate will answer it with r.err.
  function automatic bit add_txn(input obi_a_chan_t t);
    exp_q.push_back(t);
    return (exp_q.size() - 1 == err_at);
  endfunction

  task automatic build_expected(input logic [5:0] idx, input logic [31:0] arg,
                                input logic [7:0] flags);
    logic [31:0] s;
    exp_q.delete();
    exp_data = '0; exp_err = '0; exp_to = 1'b0; exp_berr = 1'b0;
    s = '0;
    if (add_txn(mk(32'h8, 1'b1, 4'hF, arg))) begin exp_berr = 1'b1; return; end
    if (add_txn(mk(32'hC, 1'b1, 4'hC, {2'b00, idx, flags, 16'h0}))) begin
      exp_berr = 1'b1; return;
    end
    for (int i = 0; i < int'(TbPollLimit); i++) begin
      s = (i < stat_q.size()) ? stat_q[i] : 32'h0;
      if (add_txn(mk(32'h30, 1'b0, 4'hF, 32'h0))) begin exp_berr = 1'b1; return; end
      if (s[15] || s[0]) begin
        exp_err = s[31:16];
        break;
      end
      if (i == int'(TbPollLimit) - 1) begin exp_to = 1'b1; return; end
    end
    if (add_txn(mk(32'h30, 1'b1, 4'hF, {s[31:16], s[15], 14'b0, 1'b1}))) begin
      exp_berr = 1'b1; return;
    end
    if (flags[1:0] != 2'b00) begin
      if (add_txn(mk(32'h10, 1'b0, 4'hF, 32'h0))) begin exp_berr = 1'b1; return; end
      exp_data = resp_val;
    end
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [7:0] flags, output int lat);
    int unsigned acc;
    int          guard;
    build_expected(idx, arg, flags);
    @(negedge clk);
    wait_ready(tag);
    obs_q.delete();
    txn_cnt   = 0;
    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_flags = flags;
    acc       = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_index = 6'($urandom);
    cmd_arg   = $urandom;
    cmd_flags = 8'($urandom);
    guard = 0;
    while (!rsp_valid && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    lat = int'(cyc - acc);
    check_eq({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    repeat (3) @(negedge clk);
    check_eq({tag, " rsp_valid held"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, " rsp_data"}, rsp_data, exp_data);
    check_eq({tag, " err_status"}, 32'(rsp_err_status), 32'(exp_err));
    check_eq({tag, " timeout"}, 32'(rsp_timeout), 32'(exp_to));
    check_eq({tag, " bus_err"}, 32'(rsp_bus_err), 32'(exp_berr));
    check_eq({tag, " txn count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("%s txn%0d addr", tag, i), obs_q[i].addr, exp_q[i].addr);
      check_eq($sformatf("%s txn%0d we", tag, i), 32'(obs_q[i].we), 32'(exp_q[i].we));
      check_eq($sformatf("%s txn%0d be", tag, i), 32'(obs_q[i].be), 32'(exp_q[i].be));
      if (exp_q[i].we)
        check_eq($sformatf("%s txn%0d wdata", tag, i), obs_q[i].wdata, exp_q[i].wdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({tag, " rsp_valid cleared"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_init(input string tag);
    int unsigned r;
    obs_q.delete();
    rst = 1'b0;
    r   = cyc;
    wait_ready(tag);
    check_eq({tag, " ready cycle"}, cyc - r, 32'd3);
    check_eq({tag, " init txn count"}, 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      check_eq({tag, " init addr"}, obs_q[0].addr, 32'h34);
      check_eq({tag, " init we"}, 32'(obs_q[0].we), 32'd1);
      check_eq({tag, " init be"}, 32'(obs_q[0].be), 32'hF);
      check_eq({tag, " init wdata"}, obs_q[0].wdata, 32'hFFFF_0001);
    end
  endtask

  initial begin
    int lat;
    int guard;
    rst = 1'b1; cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0; cmd_flags = '0;
    rsp_ready = 1'b0; resp_val = '0;
    repeat (3) @(negedge clk);
    check_eq("reset req", 32'(obi_req.req), 32'd0);
    check_eq("reset addr", obi_req.a.addr, 32'd0);
    check_eq("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset rsp_data", rsp_data, 32'd0);
    check_eq("reset flags", {rsp_err_status, 14'b0, rsp_timeout, rsp_bus_err}, 32'd0);
    check_init("init");

    stat_q = '{32'h0000_0001}; resp_val = 32'h0000_01AA; err_at = -1; gnt_fixed = 0;
    run_cmd("cmd8", 6'd8, 32'h0000_01AA, 8'h1A, lat);
    check_eq("cmd8 latency", 32'(lat), 32'd11);

    stat_q = '{32'h0, 32'h0, 32'h0, 32'h0000_0001}; resp_val = 32'h1234_5678; gnt_fixed = 2;
    run_cmd("slow gnt", 6'd55, 32'hDEAD_BEEF, 8'h19, lat);

    stat_q = '{32'h0001_8000}; resp_val = 32'h0BAD_F00D; gnt_fixed = 0;
    run_cmd("error int", 6'd17, 32'h0000_0200, 8'h1A, lat);

    stat_q.delete(); gnt_fixed = 1;
    run_cmd("timeout", 6'd13, 32'h0001_0000, 8'h1A, lat);

    stat_q = '{32'h0000_0001}; err_at = 1; gnt_fixed = 0;
    run_cmd("wr_cmd r.err", 6'd2, 32'h0, 8'h09, lat);
    err_at = -1;

    // Reset while a status read is pending
    stat_q.delete(); gnt_fixed = 2;
    @(negedge clk);
    wait_ready("rst mid");
    cmd_valid = 1'b1; cmd_index = 6'd7; cmd_arg = 32'h0001_0000; cmd_flags = 8'h1B;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!(obi_req.req && !obi_req.a.we && obi_req.a.addr == 32'h30) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("rst mid reached RD_STAT", 32'(obi_req.req), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst mid req dropped", 32'(obi_req.req), 32'd0);
    check_eq("rst mid cmd_ready", 32'(cmd_ready), 32'd0);
    gnt_fixed = 0;
    @(negedge clk);
    check_init("reinit");

    gnt_fixed = -1;
    for (int n = 0; n < 30; n++) begin
      int k;
      logic [31:0] s;
      stat_q.delete();
      k = int'($urandom_range(0, 5));
      for (int j = 0; j < k; j++) begin
        s = $urandom;
        if ($urandom_range(0, 2) != 0) begin
          s[15] = 1'b0;
          s[0]  = 1'b0;
        end
        stat_q.push_back(s);
      end
      resp_val = $urandom;
      err_at   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_cmd($sformatf("rand%0d", n), 6'($urandom), $urandom, 8'($urandom), lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
